// File: rtl/uart_pkt_pkg.sv
// Shared constants and helpers for the UART packet FIFO.
// Byte width, byte-order encodings and a constant-foldable clog2.
package uart_pkt_pkg;

    localparam int BYTE_W    = 8;
    localparam int LSB_FIRST = 0;
    localparam int MSB_FIRST = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers.
// Latency: a push is visible on rdata/empty the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sync_fifo
    import uart_pkt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // When full, a simultaneous push lands in the slot the pop is vacating.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_pkt_fifo.sv
// Packs UART bytes into DATA_WIDTH words (with byte count) and buffers them for a valid/ready drain.
// Latency: a word completed or flushed at edge N is presented in the cycle after N when the FIFO was empty.
// Backpressure: none toward UART; words arriving while the FIFO is full are dropped and counted.
module uart_pkt_fifo
    import uart_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 32,
    parameter int BYTE_ORDER = 0,
    parameter int TIMEOUT    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_rstn,
    input  logic                                   i_valid,
    input  logic [7:0]                             i_data,
    input  logic                                   i_flush,
    output logic [DATA_WIDTH-1:0]                  o_data,
    output logic [clog2(DATA_WIDTH/8+1)-1:0]       o_nbytes,
    output logic                                   o_valid,
    input  logic                                   i_ready,
    output logic                                   o_full,
    output logic                                   o_empty,
    output logic [clog2(DEPTH):0]                  o_level,
    output logic [CNT_WIDTH-1:0]                   o_drop_cnt
);

    localparam int BYTES = DATA_WIDTH / BYTE_W;
    localparam int NBW   = clog2(BYTES + 1);
    localparam int IDXW  = clog2(BYTES);
    localparam int TW    = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam int FW    = DATA_WIDTH + NBW;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    logic [IDXW-1:0]       idx;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_nxt;
    logic [TW-1:0]         idle_cnt;
    logic                  last_byte;
    logic                  flush_req;
    logic                  timeout_req;
    logic                  push;
    logic [NBW-1:0]        push_nb;
    logic                  pop;
    logic                  drop;
    logic [FW-1:0]         fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;

    always_comb begin
        asm_nxt = asm_q;
        if (i_valid) begin
            if (BYTE_ORDER == MSB_FIRST)
                asm_nxt[(BYTES-1-int'(idx))*BYTE_W +: BYTE_W] = i_data;
            else
                asm_nxt[int'(idx)*BYTE_W +: BYTE_W] = i_data;
        end
    end

    // A byte arriving with i_flush is absorbed into the flushed word.
    assign last_byte   = i_valid && (idx == IDXW'(BYTES - 1));
    assign flush_req   = i_flush && (i_valid || (idx != '0));
    assign timeout_req = (TIMEOUT > 0) && !i_valid && (idx != '0) && (idle_cnt == TO_LAST);
    assign push        = last_byte || flush_req || timeout_req;

    always_comb begin
        push_nb = NBW'(idx);
        if (last_byte)
            push_nb = NBW'(BYTES);
        else if (i_valid)
            push_nb = NBW'(idx) + NBW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            idx      <= '0;
            asm_q    <= '0;
            idle_cnt <= '0;
        end else if (push) begin
            idx      <= '0;
            asm_q    <= '0;
            idle_cnt <= '0;
        end else if (i_valid) begin
            idx      <= idx + IDXW'(1);
            asm_q    <= asm_nxt;
            idle_cnt <= '0;
        end else if ((TIMEOUT > 0) && (idx != '0)) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign pop  = o_valid && i_ready;
    assign drop = push && fifo_full && !pop;

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            o_drop_cnt <= '0;
        else if (drop && (o_drop_cnt != '1))
            o_drop_cnt <= o_drop_cnt + CNT_WIDTH'(1);
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .push   (push),
        .wdata  ({push_nb, asm_nxt}),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (o_level)
    );

    assign o_valid  = !fifo_empty;
    assign o_full   = fifo_full;
    assign o_empty  = fifo_empty;
    assign o_data   = o_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
    assign o_nbytes = o_valid ? fifo_rdata[FW-1:DATA_WIDTH] : '0;

endmodule

// File: doc/uart_pkt_fifo.md
# uart_pkt_fifo

Packs the UART receiver's byte stream into DATA_WIDTH-bit words and buffers them in a single-clock FIFO with a valid/ready drain port toward the AXI master. It sits between UART_RX and the DDR write path, and replaces the fixed packetizer/FIFO pair with a parametrised block. Beyond the fixed pair, it adds:
- configurable byte order
- idle-timeout and forced flush of partial words, with a byte count
- overflow drop counting
- fill-level reporting

## Interface
- DATA_WIDTH, 256, output word width; multiple of 8, ≥16; BYTES = DATA_WIDTH/8
- DEPTH, 32, FIFO entries; power of 2, ≥2
- BYTE_ORDER, 0, 0: first byte in bits [7:0]; 1: first byte in bits [DATA_WIDTH-1:DATA_WIDTH-8]
- TIMEOUT, 0, idle cycles before a partial word is flushed; 0 disables
- CNT_WIDTH, 16, drop counter width
- i_clk  in  1  single clock
- i_rstn  in  1  reset, synchronous, active-low
- i_valid  in  1  byte strobe from UART_RX (one-cycle pulse)
- i_data  in  8  received byte
- i_flush  in  1  push the current partial word now
- o_data  out  DATA_WIDTH  head-of-FIFO word
- o_nbytes  out  $clog2(BYTES+1)  valid bytes in o_data (BYTES for a full word)
- o_valid  out  1  head word available
- i_ready  in  1  consumer accepts the head word
- o_full  out  1  DEPTH words stored
- o_empty  out  1  no words stored
- o_level  out  $clog2(DEPTH)+1  words stored
- o_drop_cnt  out  CNT_WIDTH  words lost to overflow, saturating

## Operation
- **Packer state**
  - Lane index idx (0..BYTES-1), assembly register, idle counter.
- **Byte capture**
  - On i_valid, the byte is written to lane idx, placed per BYTE_ORDER, and idx increments.
  - When idx==BYTES-1 the word completes: push with nbytes=BYTES, then idx←0 and the assembly register is cleared to 0.
- **Flush**
  - Trigger: i_flush with idx≠0, or TIMEOUT>0, idx≠0 and TIMEOUT consecutive cycles without i_valid.
  - Pushes a word with nbytes=idx. Unused lanes are zero.
  - i_flush with idx==0 is a no-op and never pushes an empty word.
- **Simultaneous i_valid and i_flush**
  - The byte is absorbed first, then one word is pushed with nbytes=idx+1.
  - If that byte completes the word, exactly one push occurs, with nbytes=BYTES.
- **Idle counter**
  - Cleared on i_valid or on any push.
  - Counts only while idx≠0.
- **FIFO**
  - Push stores {word, nbytes}.
  - Pop occurs on o_valid && i_ready.
  - Order is strictly preserved.
- **Overflow**
  - Push while full and no pop in the same cycle: the word is dropped and o_drop_cnt increments, saturating at all-ones. The packer still clears.
  - Push and pop in the same cycle while full: both happen, level is unchanged, no drop.
  - Push and pop in the same cycle while empty: impossible, since o_valid=0.
- **Output data**
  - o_valid = !o_empty.
  - o_data and o_nbytes are forced to 0 while o_valid=0.
  - They are held stable while o_valid && !i_ready.
- **Pointers**
  - Width $clog2(DEPTH)+1, with the MSB as the wrap bit.
  - full = addresses equal and wrap bits differ; empty = pointers equal.
  - Wrap-around from DEPTH-1 to 0 is seamless.

## Timing
- **Reset values:** o_valid=0, o_empty=1, o_full=0, o_level=0, o_drop_cnt=0, o_data=0, o_nbytes=0. Reset also clears idx, the idle counter, the assembly register and the pointers.
- **Reset mid-packet:** the partial word is discarded and stored words are discarded.
- **Byte-to-output latency:** a byte completing or flushing a word at edge N gives o_valid=1 in the cycle after edge N, when the FIFO was empty.
- **Timeout:** the flush push occurs at the edge ending the TIMEOUT-th idle cycle.
- **Status outputs:** o_full, o_empty and o_level are registered and reflect the state after the previous edge.
- **Sustained throughput:** one byte per cycle in, and one word per cycle out.

## Structure
- **Shared package uart_pkt_pkg**
  - BYTE_W=8.
  - BYTE_ORDER constants LSB_FIRST=0 and MSB_FIRST=1.
  - clog2 helper.
- **Sub-module sync_fifo**
  - Parameters WIDTH and DEPTH.
  - Ports: push/pop, show-ahead read, full/empty/level.
  - Instantiated with WIDTH = DATA_WIDTH + nbytes width.
- **Top level** holds the packer, timeout logic and drop counter.

## Test plan
Bench parameters: DATA_WIDTH=32, DEPTH=4, TIMEOUT=8.
- **Reset:** assert i_rstn=0 for 2 cycles with traffic present -> o_valid=0, o_empty=1, o_level=0, o_drop_cnt=0, o_data=0.
- **Byte order:** bytes 11,22,33,44 with BYTE_ORDER=0 -> o_data=0x44332211, o_nbytes=4, o_valid one cycle after the 4th byte. With BYTE_ORDER=1 -> o_data=0x11223344.
- **Timeout flush:** bytes AA,BB then idle -> push at the end of the 8th idle cycle, o_data=0x0000BBAA, o_nbytes=2. i_flush at idx==0 -> no push.
- **Overflow:** i_ready=0, send 5 full words W1..W5 -> o_full=1, o_level=4, o_drop_cnt=1. Drain -> W1..W4 in order, then o_empty=1.
- **Push and pop while full:** i_ready=1 on the cycle a 5th word completes -> o_level stays 4, o_drop_cnt unchanged.
- **Simultaneous events and reset:**
  - i_flush together with i_valid on the 3rd byte (01,02,03) -> o_data=0x00030201, o_nbytes=3.
  - Reset after 2 bytes, then 4 new bytes -> the word contains only the new bytes.
